// File: rtl/ocp_rd_resp_assembler_if.sv
// OCP response beats in, assembled read-data packet out (valid/ready).
interface ocp_rd_resp_assembler_if #(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int MAX_BEATS = 16,
  parameter int LEN_W     = $clog2(MAX_BEATS)
);
  logic [1:0]                  SResp;
  logic [DATA_W-1:0]           SData;
  logic                        SRespLast;
  logic [TAG_W-1:0]            STagID;
  logic                        MRespAccept;
  logic                        pkt_vld;
  logic                        pkt_rdy;
  logic [TAG_W-1:0]            pkt_id;
  logic [LEN_W-1:0]            pkt_len;
  logic [MAX_BEATS*DATA_W-1:0] pkt_data;
  logic                        pkt_err;
  logic                        pkt_ovf;
  logic                        busy;

  modport slave (
    input  SResp, SData, SRespLast, STagID, pkt_rdy,
    output MRespAccept, pkt_vld, pkt_id, pkt_len, pkt_data, pkt_err, pkt_ovf, busy
  );

  modport master (
    output SResp, SData, SRespLast, STagID, pkt_rdy,
    input  MRespAccept, pkt_vld, pkt_id, pkt_len, pkt_data, pkt_err, pkt_ovf, busy
  );
endinterface

// File: rtl/ocp_rd_resp_assembler.sv
// Collects an OCP response burst into one packet; pkt_vld rises the edge after the last beat.
// MRespAccept drops only while a held packet is not taken (pkt_vld & !pkt_rdy).
module ocp_rd_resp_assembler #(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int MAX_BEATS = 16,
  parameter int LEN_W     = $clog2(MAX_BEATS)
) (
  input logic                     clk,
  input logic                     rst,
  ocp_rd_resp_assembler_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [TAG_W-1:0]            id_q;
  logic [LEN_W-1:0]            len_q;
  logic [MAX_BEATS*DATA_W-1:0] data_q;
  logic                        err_q;
  logic                        ovf_q;

  logic accept, beat_acc, pop, first, full, beat_err, tag_bad;

  assign accept   = (state == COLLECT) | bus.pkt_rdy;
  assign beat_acc = (bus.SResp != 2'b00) & accept;
  assign pop      = (state == HOLD) & bus.pkt_rdy;
  assign first    = (cnt == '0);
  assign full     = (cnt == CNT_W'(MAX_BEATS));
  assign beat_err = bus.SResp[1];
  assign tag_bad  = (bus.STagID != id_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= COLLECT;
      cnt    <= '0;
      id_q   <= '0;
      len_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (pop)
        state <= COLLECT;
      if (beat_acc) begin
        if (first) begin
          // a new packet starts clean: stale lanes from the previous one are wiped
          data_q <= {{((MAX_BEATS-1)*DATA_W){1'b0}}, bus.SData};
          id_q   <= bus.STagID;
          err_q  <= beat_err;
          ovf_q  <= 1'b0;
        end else begin
          err_q <= err_q | beat_err | tag_bad;
          ovf_q <= ovf_q | full;
          for (int k = 1; k < MAX_BEATS; k++)
            if (cnt == CNT_W'(k))
              data_q[k*DATA_W +: DATA_W] <= bus.SData;
        end
        if (bus.SRespLast) begin
          cnt   <= '0;
          len_q <= full ? '1 : cnt[LEN_W-1:0];
          state <= HOLD;
        end else if (!full) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.MRespAccept = accept;
  assign bus.pkt_vld     = (state == HOLD);
  assign bus.pkt_id      = id_q;
  assign bus.pkt_len     = len_q;
  assign bus.pkt_data    = data_q;
  // flags accumulate during collection but are only exposed with the packet
  assign bus.pkt_err     = err_q & (state == HOLD);
  assign bus.pkt_ovf     = ovf_q & (state == HOLD);
  assign bus.busy        = (cnt != '0) & (state == COLLECT);
endmodule

// File: tb/tb_ocp_rd_resp_assembler.sv
// Directed bench: default 32b/16-lane build plus a 64b/4-lane build sharing clock and reset.
module tb_ocp_rd_resp_assembler;
  localparam logic [1:0] NUL = 2'b00, DVA = 2'b01, ERR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  ocp_rd_resp_assembler_if #(.DATA_W(32), .TAG_W(4), .MAX_BEATS(16)) bi ();
  ocp_rd_resp_assembler_if #(.DATA_W(64), .TAG_W(4), .MAX_BEATS(4))  si ();

  ocp_rd_resp_assembler #(.DATA_W(32), .TAG_W(4), .MAX_BEATS(16)) u_big (
    .clk(clk), .rst(rst), .bus(bi.slave));
  ocp_rd_resp_assembler #(.DATA_W(64), .TAG_W(4), .MAX_BEATS(4)) u_small (
    .clk(clk), .rst(rst), .bus(si.slave));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // drive one beat on the 32-bit build; returns 1 time unit after the sampling edge
  task automatic beat(input logic [1:0] resp, input logic [31:0] d, input logic last,
                      input logic [3:0] tag);
    bi.SResp = resp; bi.SData = d; bi.SRespLast = last; bi.STagID = tag;
    @(posedge clk); #1;
    bi.SResp = NUL; bi.SRespLast = 1'b0;
  endtask

  task automatic idle;
    @(posedge clk); #1;
  endtask

  logic [511:0] e;
  int acc;

  initial begin
    bi.SResp = NUL; bi.SData = '0; bi.SRespLast = 1'b0; bi.STagID = '0; bi.pkt_rdy = 1'b1;
    si.SResp = NUL; si.SData = '0; si.SRespLast = 1'b0; si.STagID = '0; si.pkt_rdy = 1'b1;

    // reset state
    #1 rst = 1'b0;
    #2;
    chk("rst_vld",  bi.pkt_vld, 0);
    chk("rst_acc",  bi.MRespAccept, 1);
    chk("rst_busy", bi.busy, 0);
    chk("rst_data", bi.pkt_data, 0);
    chk("rst_len",  bi.pkt_len, 0);
    @(posedge clk); #3 rst = 1'b1;
    idle();

    // 4-beat burst, tag 3, no backpressure
    for (int i = 0; i < 4; i++) begin
      beat(DVA, 32'hA0 + i, i == 3, 4'd3);
      if (i == 1) chk("t1_busy", bi.busy, 1);
    end
    e = '0;
    for (int k = 0; k < 4; k++) e[k*32 +: 32] = 32'hA0 + k;
    chk("t1_vld",  bi.pkt_vld, 1);
    chk("t1_id",   bi.pkt_id, 3);
    chk("t1_len",  bi.pkt_len, 3);
    chk("t1_data", bi.pkt_data, e);
    chk("t1_err",  bi.pkt_err, 0);
    chk("t1_ovf",  bi.pkt_ovf, 0);
    idle();
    chk("t1_pop",  bi.pkt_vld, 0);

    // same burst held for 5 cycles while the next burst waits
    bi.pkt_rdy = 1'b0;
    for (int i = 0; i < 4; i++) beat(DVA, 32'hA0 + i, i == 3, 4'd3);
    chk("t2_vld", bi.pkt_vld, 1);
    bi.SResp = DVA; bi.SData = 32'hB0; bi.SRespLast = 1'b0; bi.STagID = 4'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_stall_acc",  bi.MRespAccept, 0);
      chk("t2_stall_data", bi.pkt_data, e);
      chk("t2_stall_id",   bi.pkt_id, 3);
      @(posedge clk);
    end
    #1 bi.pkt_rdy = 1'b1;
    #1 chk("t2_rdy_acc", bi.MRespAccept, 1);
    @(posedge clk); #1;
    bi.SResp = NUL;
    chk("t2_pop_vld",  bi.pkt_vld, 0);
    chk("t2_busy",     bi.busy, 1);
    chk("t2_new_id",   bi.pkt_id, 1);
    chk("t2_new_data", bi.pkt_data, 512'hB0);
    beat(DVA, 32'hB1, 1'b1, 4'd1);
    chk("t2_vld2", bi.pkt_vld, 1);
    chk("t2_len2", bi.pkt_len, 1);
    chk("t2_dat2", bi.pkt_data, {480'h0, 32'hB1, 32'hB0});
    idle();

    // 18 beats into 16 lanes
    acc = 0;
    for (int i = 0; i < 18; i++) begin
      bi.SResp = DVA; bi.SData = 32'hC00 + i; bi.SRespLast = (i == 17); bi.STagID = 4'd4;
      #1 if (bi.MRespAccept) acc++;
      @(posedge clk); #1;
      if (i == 16) chk("t3_ovf_hidden", bi.pkt_ovf, 0);
    end
    bi.SResp = NUL; bi.SRespLast = 1'b0;
    for (int k = 0; k < 16; k++) e[k*32 +: 32] = 32'hC00 + k;
    chk("t3_acc",  acc, 18);
    chk("t3_vld",  bi.pkt_vld, 1);
    chk("t3_len",  bi.pkt_len, 15);
    chk("t3_ovf",  bi.pkt_ovf, 1);
    chk("t3_err",  bi.pkt_err, 0);
    chk("t3_data", bi.pkt_data, e);
    idle();

    // error beat and tag mismatch
    beat(DVA, 32'hD0, 1'b0, 4'd2);
    beat(ERR, 32'hD1, 1'b0, 4'd2);
    beat(DVA, 32'hD2, 1'b1, 4'd5);
    chk("t4_err",  bi.pkt_err, 1);
    chk("t4_ovf",  bi.pkt_ovf, 0);
    chk("t4_id",   bi.pkt_id, 2);
    chk("t4_len",  bi.pkt_len, 2);
    chk("t4_data", bi.pkt_data, {416'h0, 32'hD2, 32'hD1, 32'hD0});
    idle();

    // tag mismatch alone
    beat(DVA, 32'hF0, 1'b0, 4'd9);
    beat(DVA, 32'hF1, 1'b1, 4'd8);
    chk("t4b_err", bi.pkt_err, 1);
    chk("t4b_id",  bi.pkt_id, 9);
    idle();

    // reset mid-burst, NULL-with-last ignored, then fresh 1-beat packet
    beat(DVA, 32'hE0, 1'b0, 4'd6);
    beat(DVA, 32'hE1, 1'b0, 4'd6);
    rst = 1'b0;
    #2;
    chk("t5_rst_busy", bi.busy, 0);
    chk("t5_rst_data", bi.pkt_data, 0);
    chk("t5_rst_id",   bi.pkt_id, 0);
    chk("t5_rst_acc",  bi.MRespAccept, 1);
    @(posedge clk); #3 rst = 1'b1;
    idle();
    beat(NUL, 32'hFF, 1'b1, 4'd1);
    chk("t5_null_vld",  bi.pkt_vld, 0);
    chk("t5_null_busy", bi.busy, 0);
    beat(DVA, 32'h55, 1'b1, 4'd7);
    chk("t5_vld",  bi.pkt_vld, 1);
    chk("t5_len",  bi.pkt_len, 0);
    chk("t5_id",   bi.pkt_id, 7);
    chk("t5_data", bi.pkt_data, 512'h55);
    idle();

    // 64-bit / 4-lane build: single-beat packets every cycle
    for (int i = 0; i < 4; i++) begin
      si.SResp = DVA; si.SData = 64'hFEDC_BA98_0000_0000 | 64'(i);
      si.SRespLast = 1'b1; si.STagID = 4'(i);
      #1 chk("t6_acc", si.MRespAccept, 1);
      @(posedge clk); #1;
      chk("t6_vld",  si.pkt_vld, 1);
      chk("t6_id",   si.pkt_id, i);
      chk("t6_len",  si.pkt_len, 0);
      chk("t6_data", si.pkt_data, {192'h0, 64'hFEDC_BA98_0000_0000 | 64'(i)});
    end
    si.SResp = NUL; si.SRespLast = 1'b0;
    idle();
    chk("t6_pop", si.pkt_vld, 0);

    // 3-beat burst on the 64-bit build
    for (int i = 0; i < 3; i++) begin
      si.SResp = DVA; si.SData = 64'h0123_4567_89AB_CDE0 + 64'(i);
      si.SRespLast = (i == 2); si.STagID = 4'hA;
      @(posedge clk); #1;
    end
    si.SResp = NUL; si.SRespLast = 1'b0;
    chk("t7_vld",  si.pkt_vld, 1);
    chk("t7_len",  si.pkt_len, 2);
    chk("t7_id",   si.pkt_id, 4'hA);
    chk("t7_data", si.pkt_data, {64'h0, 64'h0123_4567_89AB_CDE2,
                                 64'h0123_4567_89AB_CDE1, 64'h0123_4567_89AB_CDE0});
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
